// File: rtl/echo_capture_multi.sv
// Multi-channel echo pulse capture: per-channel start timestamp, pulse width,
// width timeout and a sticky missed-edge flag, all against an external timer.
module echo_capture_multi #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned TIMER_WIDTH = 13,
    parameter int unsigned EDGE_MODE   = 0,
    parameter int unsigned MAX_WIDTH   = 1000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [TIMER_WIDTH-1:0]          timer,
    input  logic [CHANNELS-1:0]             echo,
    input  logic [CHANNELS-1:0]             arm,
    output logic [CHANNELS*TIMER_WIDTH-1:0] echo_time,
    output logic [CHANNELS*TIMER_WIDTH-1:0] echo_width,
    output logic [CHANNELS-1:0]             valid,
    output logic [CHANNELS-1:0]             timeout,
    output logic [CHANNELS-1:0]             missed
);

    localparam int unsigned   TW    = TIMER_WIDTH;
    localparam logic [TW-1:0] MAX_W = TW'(MAX_WIDTH);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_e;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        state_e        state_q, state_d;
        logic          echo_q;
        logic [TW-1:0] time_q, time_d;
        logic [TW-1:0] width_q, width_d;
        logic          valid_q, valid_d;
        logic          timeout_q, timeout_d;
        logic          missed_q, missed_d;
        logic [TW-1:0] elapsed_c;
        logic          edge_c, start_c;

        // Channel state register; echo_q tracks the input even while arm is asserted.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= ARMED;
                echo_q    <= 1'b0;
                time_q    <= '0;
                width_q   <= '0;
                valid_q   <= 1'b0;
                timeout_q <= 1'b0;
                missed_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                echo_q    <= echo[k];
                time_q    <= time_d;
                width_q   <= width_d;
                valid_q   <= valid_d;
                timeout_q <= timeout_d;
                missed_q  <= missed_d;
            end
        end

        // Next-state logic; arm beats any edge, end edge beats timeout.
        always_comb begin
            state_d   = state_q;
            time_d    = time_q;
            width_d   = width_q;
            valid_d   = valid_q;
            timeout_d = timeout_q;
            missed_d  = missed_q;
            elapsed_c = timer - time_q;
            edge_c    = echo[k] ^ echo_q;
            if (EDGE_MODE == 32'd1) begin
                start_c = echo[k] & ~echo_q;
            end else if (EDGE_MODE == 32'd2) begin
                start_c = ~echo[k] & echo_q;
            end else begin
                start_c = edge_c;
            end

            if (arm[k]) begin
                state_d   = ARMED;
                time_d    = '0;
                width_d   = '0;
                valid_d   = 1'b0;
                timeout_d = 1'b0;
                missed_d  = 1'b0;
            end else begin
                case (state_q)
                    ARMED: begin
                        if (start_c) begin
                            time_d  = timer;
                            state_d = MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (edge_c) begin
                            width_d = elapsed_c;
                            valid_d = 1'b1;
                            state_d = DONE;
                        end else if (elapsed_c >= MAX_W) begin
                            width_d   = MAX_W;
                            timeout_d = 1'b1;
                            valid_d   = 1'b1;
                            state_d   = DONE;
                        end
                    end
                    DONE: begin
                        if (start_c) begin
                            missed_d = 1'b1;
                        end
                    end
                    default: state_d = ARMED;
                endcase
            end
        end

        assign echo_time[k*TW +: TW]  = time_q;
        assign echo_width[k*TW +: TW] = width_q;
        assign valid[k]               = valid_q;
        assign timeout[k]             = timeout_q;
        assign missed[k]              = missed_q;
    end

endmodule

// File: tb/tb_echo_capture_multi.sv
// Self-checking bench for echo_capture_multi: a 4-channel rising-edge instance
// with a result scoreboard, plus a single-channel any-edge instance.
module tb_echo_capture_multi;

    localparam int unsigned CH = 4;
    localparam int unsigned TW = 13;

    typedef struct {
        int ch;
        int t;
        int w;
        int to;
        int lat;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [TW-1:0]       timer;
    logic [CH-1:0]       echo_a, arm_a;
    logic [CH*TW-1:0]    time_a, width_a;
    logic [CH-1:0]       valid_a, timeout_a, missed_a;
    logic                echo_b, arm_b;
    logic [TW-1:0]       time_b, width_b;
    logic                valid_b, timeout_b, missed_b;

    int   n_vec;
    int   n_err;
    exp_t sb[$];

    echo_capture_multi #(
        .CHANNELS(4), .TIMER_WIDTH(13), .EDGE_MODE(1), .MAX_WIDTH(1000)
    ) u_dut_a (
        .clk(clk), .reset(reset), .timer(timer), .echo(echo_a), .arm(arm_a),
        .echo_time(time_a), .echo_width(width_a), .valid(valid_a),
        .timeout(timeout_a), .missed(missed_a)
    );

    echo_capture_multi #(
        .CHANNELS(1), .TIMER_WIDTH(13), .EDGE_MODE(0), .MAX_WIDTH(1000)
    ) u_dut_b (
        .clk(clk), .reset(reset), .timer(timer), .echo(echo_b), .arm(arm_b),
        .echo_time(time_b), .echo_width(width_b), .valid(valid_b),
        .timeout(timeout_b), .missed(missed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int f_time(input int ch);
        return int'(time_a[ch*TW +: TW]);
    endfunction
    function automatic int f_width(input int ch);
        return int'(width_a[ch*TW +: TW]);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        timer = timer + 1'b1;
    endtask

    task automatic set_t(input int t);
        timer = TW'(t);
    endtask

    task automatic push(input int ch, input int t, input int w, input int to, input int lat);
        exp_t e;
        e.ch = ch; e.t = t; e.w = w; e.to = to; e.lat = lat;
        sb.push_back(e);
    endtask

    // Pop each expected result, wait (bounded) for its channel to report valid.
    task automatic drain();
        exp_t e;
        int   waited;
        bit   ok;
        while (sb.size() > 0) begin
            e      = sb.pop_front();
            ok     = 1'b0;
            waited = 0;
            for (int i = 0; i < 1200; i++) begin
                if (valid_a[e.ch]) begin
                    ok = 1'b1;
                    break;
                end
                cyc();
                waited++;
            end
            chk($sformatf("ch%0d valid_seen", e.ch), int'(ok), 1);
            chk($sformatf("ch%0d latency", e.ch), waited, e.lat);
            chk($sformatf("ch%0d echo_time", e.ch), f_time(e.ch), e.t);
            chk($sformatf("ch%0d echo_width", e.ch), f_width(e.ch), e.w);
            chk($sformatf("ch%0d timeout", e.ch), int'(timeout_a[e.ch]), e.to);
        end
    endtask

    task automatic chk_clear(input int ch, input string tag);
        chk($sformatf("%s ch%0d time", tag, ch), f_time(ch), 0);
        chk($sformatf("%s ch%0d width", tag, ch), f_width(ch), 0);
        chk($sformatf("%s ch%0d valid", tag, ch), int'(valid_a[ch]), 0);
        chk($sformatf("%s ch%0d timeout", tag, ch), int'(timeout_a[ch]), 0);
        chk($sformatf("%s ch%0d missed", tag, ch), int'(missed_a[ch]), 0);
    endtask

    task automatic arm_ch(input int ch);
        arm_a[ch] = 1'b1;
        cyc();
        arm_a[ch] = 1'b0;
        chk_clear(ch, "arm");
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b1;
        timer  = '0;
        echo_a = '0;
        arm_a  = '0;
        echo_b = 1'b0;
        arm_b  = 1'b0;

        // Reset overrides arm and echo.
        cyc();
        arm_a  = '1;
        echo_a = '1;
        cyc();
        for (int c = 0; c < 4; c++) chk_clear(c, "reset");
        chk("reset b time", int'(time_b), 0);
        chk("reset b valid", int'(valid_b), 0);
        echo_a = '0;
        arm_a  = '0;
        reset  = 1'b0;
        cyc();
        cyc();

        // Basic width.
        set_t(100); echo_a[0] = 1'b1; cyc();
        chk("width start", f_time(0), 100);
        chk("width valid early", int'(valid_a[0]), 0);
        set_t(350); echo_a[0] = 1'b0; push(0, 100, 250, 0, 0); cyc();
        drain();
        chk("width missed", int'(missed_a[0]), 0);
        arm_ch(0);

        // Timer wrap.
        set_t(8190); echo_a[1] = 1'b1; cyc();
        set_t(3); echo_a[1] = 1'b0; push(1, 8190, 5, 0, 0); cyc();
        drain();
        arm_ch(1);

        // Timeout with echo held high.
        set_t(10); echo_a[2] = 1'b1; cyc();
        push(2, 10, 1000, 1, 1000);
        drain();
        chk("timeout timer", int'(timer) - 1, 1010);
        echo_a[2] = 1'b0; cyc();
        chk("done fall no missed", int'(missed_a[2]), 0);
        echo_a[2] = 1'b1; cyc();
        chk("done rise missed", int'(missed_a[2]), 1);
        chk("done hold time", f_time(2), 10);
        chk("done hold width", f_width(2), 1000);
        arm_ch(2);
        echo_a[2] = 1'b0; cyc();

        // End edge exactly at the timeout boundary wins.
        set_t(10); echo_a[3] = 1'b1; cyc();
        set_t(1010); echo_a[3] = 1'b0; push(3, 10, 1000, 0, 0); cyc();
        drain();
        arm_ch(3);

        // Arm and rise on the same edge: edge discarded.
        set_t(200); echo_a[0] = 1'b1; cyc();
        set_t(210); echo_a[0] = 1'b0; push(0, 200, 10, 0, 0); cyc();
        drain();
        arm_a[0] = 1'b1; echo_a[0] = 1'b1; cyc();
        arm_a[0] = 1'b0;
        chk_clear(0, "collide");
        cyc(); cyc(); cyc();
        chk("collide hold", f_time(0), 0);
        echo_a[0] = 1'b0; cyc();
        chk("collide fall", f_time(0), 0);
        set_t(500); echo_a[0] = 1'b1; cyc();
        chk("collide recapture", f_time(0), 500);
        set_t(530); echo_a[0] = 1'b0; push(0, 500, 30, 0, 0); cyc();
        drain();
        arm_ch(0);

        // Four channels, channel 2 re-armed mid-pulse.
        set_t(5);
        echo_a[0] = 1'b1; cyc();
        echo_a[1] = 1'b1; cyc();
        echo_a[2] = 1'b1; cyc();
        echo_a[3] = 1'b1; cyc();
        cyc(); cyc();
        arm_a[2] = 1'b1; cyc();
        arm_a[2] = 1'b0;
        set_t(50); echo_a = '0;
        push(0, 5, 45, 0, 0);
        push(1, 6, 44, 0, 0);
        push(3, 8, 42, 0, 0);
        cyc();
        drain();
        chk_clear(2, "multi");
        arm_a = '1; cyc(); arm_a = '0;

        // Reset mid-measure; echo high through release counts as a rise.
        set_t(600); echo_a[0] = 1'b1; cyc();
        chk("premature start", f_time(0), 600);
        reset = 1'b1; cyc();
        chk_clear(0, "reset mid");
        reset = 1'b0; set_t(700); cyc();
        chk("release rise", f_time(0), 700);
        set_t(720); echo_a[0] = 1'b0; push(0, 700, 20, 0, 0); cyc();
        drain();

        // Single-channel any-edge instance.
        reset = 1'b1; cyc();
        reset = 1'b0; set_t(95);
        while (timer != TW'(99)) begin
            cyc();
            chk("legacy pre", int'(time_b), 0);
        end
        echo_b = 1'b1; cyc();
        chk("legacy time", int'(time_b), 99);
        chk("legacy valid early", int'(valid_b), 0);
        echo_b = 1'b0; cyc();
        chk("legacy valid", int'(valid_b), 1);
        chk("legacy width", int'(width_b), 1);
        chk("legacy missed early", int'(missed_b), 0);
        echo_b = 1'b1; cyc();
        chk("legacy missed", int'(missed_b), 1);
        chk("legacy time hold", int'(time_b), 99);
        chk("legacy timeout", int'(timeout_b), 0);
        arm_b = 1'b1; cyc(); arm_b = 1'b0;
        chk("legacy arm time", int'(time_b), 0);
        chk("legacy arm missed", int'(missed_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
